// File: rtl/modn_pkg.sv
// Shared definitions for the modulo-N counter: default sizing, Gray conversion
// and the parameter legality check used at elaboration.
package modn_pkg;

    localparam int DEFAULT_MODULUS = 6;
    localparam int DEFAULT_WIDTH   = 4;

    // Callers truncate the result to their own width; the upper bits stay zero.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic bit modn_legal(input int modulus, input int width);
        return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
    endfunction

endpackage

// File: rtl/modn_prescaler.sv
// Divides the count enable by PRESCALE: tick fires on the last enabled cycle
// of each PRESCALE-long phase; sync_zero restarts the phase.
module modn_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_zero,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (sync_zero || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/modn_sync_counter.sv
// Parametrised modulo-N up/down counter with prescaler, clear, load and
// terminal-count strobe. Define MODN_GRAY_OUT_EN to add the registered y_gray output.
module modn_sync_counter
    import modn_pkg::*;
#(
    parameter int MODULUS  = DEFAULT_MODULUS,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             load_err
`ifdef MODN_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] y_gray
`endif
);

    generate
        if (!modn_legal(MODULUS, WIDTH) || PRESCALE < 1) begin : g_bad_params
            $error("modn_sync_counter: illegal MODULUS/WIDTH/PRESCALE combination");
        end
    endgenerate

    // One extra bit so MODULUS == 2**WIDTH is representable in comparisons.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] Y_MAX = WIDTH'(MODULUS - 1);

    logic             load_ok;
    logic             y_oob;
    logic             presc_en;
    logic             presc_zero;
    logic             tick;
    logic [WIDTH-1:0] y_next;
    logic             err_next;

    assign load_ok    = ({1'b0, load_val} < MOD_W);
    assign y_oob      = ({1'b0, y} >= MOD_W);
    // Clear or any load suspends the prescaler; only a legal load restarts it.
    assign presc_en   = en && !clr && !load;
    assign presc_zero = clr || (load && load_ok);

    modn_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en        (presc_en),
        .sync_zero (presc_zero),
        .tick      (tick)
    );

    assign tc = tick && (up_dn ? (y == Y_MAX) : (y == '0));

    always_comb begin
        y_next   = y;
        err_next = 1'b0;
        if (clr) begin
            y_next = '0;
        end else if (load) begin
            if (load_ok) begin
                y_next = load_val;
            end else begin
                err_next = 1'b1;
            end
        end else if (tick) begin
            if (y_oob) begin
                y_next = '0;
            end else if (up_dn) begin
                y_next = (y == Y_MAX) ? '0 : y + WIDTH'(1);
            end else begin
                y_next = (y == '0) ? Y_MAX : y - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y        <= '0;
            load_err <= 1'b0;
        end else begin
            y        <= y_next;
            load_err <= err_next;
        end
    end

`ifdef MODN_GRAY_OUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_gray <= '0;
        end else begin
            y_gray <= WIDTH'(bin2gray(32'(y_next)));
        end
    end
`endif

endmodule

// File: tb/tb_modn_sync_counter.sv
// Bench for modn_sync_counter: three instances (mod-6, mod-6 prescale-3, mod-16)
// share stimulus and are compared against an arithmetic reference model.
module tb_modn_sync_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr, load, en, up_dn;
    logic [3:0] load_val;
    logic [3:0] y0, y1, y2;
    logic       tc0, tc1, tc2;
    logic       e0, e1, e2;
`ifdef MODN_GRAY_OUT_EN
    logic [3:0] g0, g1, g2;
    int         prev_g2;
`endif

    int errors = 0;
    int checks = 0;

    int mods[3] = '{6, 6, 16};
    int pres[3] = '{1, 3, 1};
    int m_y[3], m_ps[3], m_err[3];
    bit m_step[3];

    // clock / reset block
    always #5 clk = ~clk;

    modn_sync_counter #(.MODULUS(6), .WIDTH(4), .PRESCALE(1)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .y(y0), .tc(tc0), .load_err(e0)
`ifdef MODN_GRAY_OUT_EN
        , .y_gray(g0)
`endif
    );

    modn_sync_counter #(.MODULUS(6), .WIDTH(4), .PRESCALE(3)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .y(y1), .tc(tc1), .load_err(e1)
`ifdef MODN_GRAY_OUT_EN
        , .y_gray(g1)
`endif
    );

    modn_sync_counter #(.MODULUS(16), .WIDTH(4), .PRESCALE(1)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .y(y2), .tc(tc2), .load_err(e2)
`ifdef MODN_GRAY_OUT_EN
        , .y_gray(g2)
`endif
    );

    typedef struct {
        bit       c;
        bit       l;
        bit [3:0] lv;
        bit       e;
        bit       u;
        int       exp_y;
        bit       exp_tc;
        bit       exp_err;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int get_y(input int k);
        case (k)
            0:       return int'(y0);
            1:       return int'(y1);
            default: return int'(y2);
        endcase
    endfunction

    function automatic int get_tc(input int k);
        case (k)
            0:       return int'(tc0);
            1:       return int'(tc1);
            default: return int'(tc2);
        endcase
    endfunction

    function automatic int get_err(input int k);
        case (k)
            0:       return int'(e0);
            1:       return int'(e1);
            default: return int'(e2);
        endcase
    endfunction

`ifdef MODN_GRAY_OUT_EN
    function automatic int get_g(input int k);
        case (k)
            0:       return int'(g0);
            1:       return int'(g1);
            default: return int'(g2);
        endcase
    endfunction
`endif

    // reference model: terminal count is "this step wraps"
    function automatic int model_tc(input int k);
        bit tick;
        tick = en && !clr && !load && (m_ps[k] == pres[k] - 1);
        if (!tick) return 0;
        if (up_dn) return int'(m_y[k] == mods[k] - 1);
        return int'(m_y[k] == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_y[k] = 0; m_ps[k] = 0; m_err[k] = 0; m_step[k] = 0;
        end
`ifdef MODN_GRAY_OUT_EN
        prev_g2 = 0;
`endif
    endtask

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            m_step[k] = 0;
            if (clr) begin
                m_y[k] = 0; m_ps[k] = 0; m_err[k] = 0;
            end else if (load) begin
                if (int'(load_val) < mods[k]) begin
                    m_y[k] = int'(load_val); m_ps[k] = 0; m_err[k] = 0;
                end else begin
                    m_err[k] = 1;
                end
            end else begin
                m_err[k] = 0;
                if (en) begin
                    if (m_ps[k] == pres[k] - 1) begin
                        m_ps[k] = 0;
                        m_y[k] = up_dn ? (m_y[k] + 1) % mods[k] : (m_y[k] + mods[k] - 1) % mods[k];
                        m_step[k] = 1;
                    end else begin
                        m_ps[k]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s y[%0d]", tag, k), get_y(k), m_y[k]);
            check($sformatf("%s tc[%0d]", tag, k), get_tc(k), model_tc(k));
            check($sformatf("%s load_err[%0d]", tag, k), get_err(k), m_err[k]);
`ifdef MODN_GRAY_OUT_EN
            check($sformatf("%s y_gray[%0d]", tag, k), get_g(k), m_y[k] ^ (m_y[k] >> 1));
`endif
        end
`ifdef MODN_GRAY_OUT_EN
        if (m_step[2]) check($sformatf("%s gray_1bit", tag), $countones(get_g(2) ^ prev_g2), 1);
        prev_g2 = get_g(2);
`endif
    endtask

    // driver tasks
    task automatic apply(input bit c, input bit l, input logic [3:0] lv, input bit e, input bit u);
        clr = c; load = l; load_val = lv; en = e; up_dn = u;
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input bit c, input bit l, input logic [3:0] lv, input bit e, input bit u,
                         input string tag);
        apply(c, l, lv, e, u);
        @(negedge clk);
        check_all(tag);
        advance();
    endtask

    bit pe[9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
    int py[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 2};

    initial begin
        // mod-6 instance, hand-derived: up count, down count, load, illegal load, clr vs load
        vecs[0]  = '{0, 0, 0, 1, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 1, 1, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 1, 2, 0, 0};
        vecs[3]  = '{0, 0, 0, 1, 1, 3, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 1, 4, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 1, 5, 1, 0};
        vecs[6]  = '{0, 0, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 0, 0, 1, 0};
        vecs[8]  = '{0, 0, 0, 1, 0, 5, 0, 0};
        vecs[9]  = '{0, 0, 0, 1, 0, 4, 0, 0};
        vecs[10] = '{0, 0, 0, 1, 0, 3, 0, 0};
        vecs[11] = '{0, 0, 0, 1, 0, 2, 0, 0};
        vecs[12] = '{0, 0, 0, 1, 0, 1, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{0, 1, 3, 1, 1, 0, 0, 0};
        vecs[15] = '{0, 1, 7, 1, 1, 3, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 1, 3, 0, 1};
        vecs[17] = '{0, 0, 0, 0, 1, 3, 0, 0};
        vecs[18] = '{1, 1, 2, 1, 1, 3, 0, 0};
        vecs[19] = '{0, 0, 0, 0, 1, 0, 0, 0};

        rst = 1'b0;
        apply(0, 0, 0, 0, 1);
        model_reset();
        #2;
        check_all("reset");
        #8;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            apply(vecs[i].c, vecs[i].l, vecs[i].lv, vecs[i].e, vecs[i].u);
            @(negedge clk);
            check($sformatf("vec%0d y", i), int'(y0), vecs[i].exp_y);
            check($sformatf("vec%0d tc", i), int'(tc0), int'(vecs[i].exp_tc));
            check($sformatf("vec%0d load_err", i), int'(e0), int'(vecs[i].exp_err));
            check_all($sformatf("vec%0d", i));
            advance();
        end

        // prescale 3: a 2-cycle en gap mid-phase delays the next step by 2 cycles
        cycle(1, 0, 0, 0, 1, "pre_clr");
        for (int i = 0; i < 9; i++) begin
            apply(0, 0, 0, pe[i], 1);
            @(negedge clk);
            check($sformatf("prescale%0d y1", i), int'(y1), py[i]);
            check_all($sformatf("prescale%0d", i));
            advance();
        end

        // asynchronous reset between edges while y=4
        cycle(1, 0, 0, 0, 1, "ar_clr");
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, "ar_cnt");
        apply(0, 0, 0, 0, 1);
        @(negedge clk);
        check("ar_pre y0", int'(y0), 4);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("ar y0", int'(y0), 0);
        check("ar y2", int'(y2), 0);
        check_all("async_rst");
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // mod-16 run through the 15->0 wrap
        for (int i = 0; i < 18; i++) cycle(0, 0, 0, 1, 1, "wrap16");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                  4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modn_sync_counter.md
Name: modn_sync_counter

Overview:
- Parametrised synchronous modulo-N counter; next generation of the fixed mod-6 counter.
- Adds configurable modulus and width, up/down mode, count enable, synchronous clear and parallel load.
- Adds a clock prescaler and a terminal-count strobe.
- Used as a divider/sequencer in the assignment designs; drives downstream logic and benches via `y` and `tc`.

Parameters:
- MODULUS, 6: count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2**WIDTH.
- WIDTH, 4: width of `y` and `load_val`.
- PRESCALE, 1: enabled clock cycles per count step; must be ≥ 1; 1 means step every enabled cycle.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- clr  input  1  synchronous clear
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value loaded when `load`=1
- en  input  1  count enable
- up_dn  input  1  1 = count up, 0 = count down
- y  output  WIDTH  registered count
- tc  output  1  terminal-count strobe (combinational)
- load_err  output  1  registered flag: illegal load attempted

Behaviour:
- Reset (`rst`=0, asynchronous): y=0, prescaler=0, load_err=0. The counter leaves reset on the first rising edge after `rst` rises.
- Per-edge priority: rst > clr > load > en. Lower-priority inputs are ignored in a cycle where a higher one acts.
- `clr`: y←0, prescaler←0.
- `load` with load_val < MODULUS: y←load_val, prescaler←0, load_err←0.
- `load` with load_val ≥ MODULUS: y and prescaler hold; load_err←1 for exactly one cycle.
- `load_err` is 0 in every cycle not following an illegal load.
- Prescaler:
  - Internal counter 0..PRESCALE-1.
  - Increments only when en=1 and no clr/load.
  - Holds when en=0.
  - tick = en && (prescaler == PRESCALE-1); on tick the prescaler wraps to 0.
  - PRESCALE=1 gives tick = en.
- Count step on tick:
  - up_dn=1: y = (y == MODULUS-1) ? 0 : y+1
  - up_dn=0: y = (y == 0) ? MODULUS-1 : y-1
- tc = tick && ((up_dn && y == MODULUS-1) || (!up_dn && y == 0)). High in the cycle before the wrap edge; never high while clr or load is asserted.
- Latency: one clock from tick, clr or load to the updated `y`.
- `up_dn` changes take effect on the next tick; there is no pipeline.
- If MODULUS < 2**WIDTH, values ≥ MODULUS are unreachable except through X-injection. A y ≥ MODULUS on the next step is forced to 0.
- Reset mid-count: immediate clear of all state, regardless of clk.
- Elaboration error if MODULUS > 2**WIDTH, MODULUS < 2, or PRESCALE < 1.

Optional Feature:
- Macro: MODN_GRAY_OUT_EN.
- Defined:
  - Extra output `y_gray` [WIDTH], registered Gray code of the next `y` value, updated on the same edge as `y`.
  - y_gray = y ^ (y >> 1).
  - Reset value 0.
  - Intended for clock-domain-crossing consumers; Gray property is guaranteed only when MODULUS = 2**WIDTH.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `modn_pkg`:
  - Localparams for the default MODULUS/WIDTH.
  - Function `bin2gray`.
  - Function `modn_legal(MODULUS, WIDTH)` used by the elaboration check.
- Sub-module `modn_prescaler` (PRESCALE parameter; inputs clk, rst, en, sync_zero; output tick). Instantiated once.
- Counter arithmetic stays in the top module.

Test Plan:
- Default params, rst low 10 ns then high, en=1, up_dn=1 → y sequence 0,1,2,3,4,5,0; tc high only while y=5.
- up_dn=0 from y=0 → y=5,4,3,2,1,0,5; tc high only while y=0.
- load=1, load_val=3 → y=3 next cycle. Then load_val=7 → y holds, load_err=1 for one cycle, then 0.
- PRESCALE=3, en=1 → y increments every 3rd cycle. Deasserting en for 2 cycles mid-phase delays the next step by exactly 2 cycles.
- Drive rst low asynchronously between edges at y=4 → y=0 immediately. clr and load together → clr wins, y=0.
- MODULUS=16, WIDTH=4, MODN_GRAY_OUT_EN defined → y_gray changes exactly one bit per step across the 15→0 wrap.
